// File: rtl/rect_layer_if.sv
// Config, commit and pixel-stream bundle of the rectangle overlay stage.
// The master drives config and input pixels; the slave is the overlay itself.
interface rect_layer_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_slot;
  logic        cfg_en;
  logic [10:0] cfg_x;
  logic [11:0] cfg_y;
  logic [10:0] cfg_w;
  logic [11:0] cfg_h;
  logic [23:0] cfg_rgb;
  logic        commit;
  logic        commit_pending;
  logic        pix_valid;
  logic [10:0] x;
  logic [11:0] y;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic        pix_valid_out;
  logic [10:0] x_out;
  logic [11:0] y_out;
  logic [7:0]  r_out;
  logic [7:0]  g_out;
  logic [7:0]  b_out;

  modport master (
    output cfg_valid, cfg_slot, cfg_en, cfg_x, cfg_y, cfg_w, cfg_h, cfg_rgb, commit,
    output pix_valid, x, y, r, g, b,
    input  cfg_ready, commit_pending, pix_valid_out, x_out, y_out, r_out, g_out, b_out
  );

  modport slave (
    input  cfg_valid, cfg_slot, cfg_en, cfg_x, cfg_y, cfg_w, cfg_h, cfg_rgb, commit,
    input  pix_valid, x, y, r, g, b,
    output cfg_ready, commit_pending, pix_valid_out, x_out, y_out, r_out, g_out, b_out
  );
endinterface

// File: rtl/rect_layer_ctrl.sv
// Run-time configurable rectangle overlay: shadow/active descriptor banks swapped
// at a frame start, and a 2-stage hit-test / priority-select pixel pipeline.
module rect_layer_ctrl #(
  parameter int NUM_RECTS = 4
) (
  input logic         clk,
  input logic         rst,
  rect_layer_if.slave bus
);
  typedef struct packed {
    logic        en;
    logic [10:0] x;
    logic [11:0] y;
    logic [10:0] w;
    logic [11:0] h;
    logic [23:0] rgb;
  } rect_t;

  rect_t shadow   [NUM_RECTS];
  rect_t active   [NUM_RECTS];
  rect_t table_p0 [NUM_RECTS];
  logic  commit_pending;
  logic  frame_start;
  logic  apply;
  logic  cfg_wr;

  logic [NUM_RECTS-1:0] hit_p1;
  logic [23:0]          rgb_p1 [NUM_RECTS];
  logic                 vld_p1;
  logic [10:0]          x_p1;
  logic [11:0]          y_p1;
  logic [23:0]          pix_rgb_p1;

  logic [23:0] sel_rgb;
  logic        vld_p2;
  logic [10:0] x_p2;
  logic [11:0] y_p2;
  logic [23:0] rgb_p2;

  // Far edges are formed one bit wider so a rectangle touching the coordinate
  // maximum cannot wrap around and hit near zero.
  function automatic logic covers(rect_t d, logic [10:0] px, logic [11:0] py);
    logic [11:0] x_end;
    logic [12:0] y_end;
    x_end = {1'b0, d.x} + {1'b0, d.w};
    y_end = {1'b0, d.y} + {1'b0, d.h};
    return d.en && (px >= d.x) && ({1'b0, px} < x_end)
                && (py >= d.y) && ({1'b0, py} < y_end);
  endfunction

  assign frame_start        = bus.pix_valid && (bus.x == 11'd0) && (bus.y == 12'd0);
  assign apply              = commit_pending && frame_start;
  assign cfg_wr             = bus.cfg_valid && !commit_pending;
  assign bus.cfg_ready      = !commit_pending;
  assign bus.commit_pending = commit_pending;

  // The frame-start pixel that applies a commit already sees the new table.
  always_comb begin
    for (int i = 0; i < NUM_RECTS; i++) begin
      table_p0[i] = apply ? shadow[i] : active[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      commit_pending <= 1'b0;
      for (int i = 0; i < NUM_RECTS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_RECTS; i++) begin
        if (cfg_wr && (bus.cfg_slot == 3'(i))) begin
          shadow[i] <= {bus.cfg_en, bus.cfg_x, bus.cfg_y, bus.cfg_w, bus.cfg_h, bus.cfg_rgb};
        end
        if (apply) begin
          active[i] <= shadow[i];
        end
      end
      if (apply) begin
        commit_pending <= 1'b0;
      end else if (bus.commit) begin
        commit_pending <= 1'b1;
      end
    end
  end

  // ---- stage 1: per-slot hit bits, slot colours, pixel ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= bus.pix_valid;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_RECTS; i++) begin
      hit_p1[i] <= covers(table_p0[i], bus.x, bus.y);
      rgb_p1[i] <= table_p0[i].rgb;
    end
    x_p1       <= bus.x;
    y_p1       <= bus.y;
    pix_rgb_p1 <= {bus.r, bus.g, bus.b};
  end

  // ---- stage 2: highest-index hitting slot wins ----
  always_comb begin
    sel_rgb = pix_rgb_p1;
    for (int i = 0; i < NUM_RECTS; i++) begin
      if (hit_p1[i]) begin
        sel_rgb = rgb_p1[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      x_p2   <= '0;
      y_p2   <= '0;
      rgb_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      x_p2   <= x_p1;
      y_p2   <= y_p1;
      rgb_p2 <= sel_rgb;
    end
  end

  assign bus.pix_valid_out = vld_p2;
  assign bus.x_out         = x_p2;
  assign bus.y_out         = y_p2;
  assign bus.r_out         = rgb_p2[23:16];
  assign bus.g_out         = rgb_p2[15:8];
  assign bus.b_out         = rgb_p2[7:0];
endmodule

// File: doc/rect_layer_ctrl.md
# rect_layer_ctrl

Runtime-configurable rectangle overlay stage for the pixel stream. Holds a table of up to NUM_RECTS rectangle descriptors: a shadow bank written over a valid/ready config port, and an active bank loaded only at a frame boundary so a frame never tears. Each streamed pixel passes through a 2-stage pipeline. The colour of the highest-priority enabled rectangle covering the pixel replaces the input colour. This block replaces fixed-parameter rectangle stages wherever shapes must move or recolour at run time.

## Interface
- NUM_RECTS, 4, number of descriptor slots, 1..8.
- clk  in  1  pipeline and config clock.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  descriptor write request.
- cfg_ready  out  1  descriptor write accepted when high together with cfg_valid.
- cfg_slot  in  3  target slot. Slots >= NUM_RECTS are accepted and discarded.
- cfg_en  in  1  slot enable.
- cfg_x  in  11  left edge.
- cfg_y  in  12  top edge.
- cfg_w  in  11  width in pixels.
- cfg_h  in  12  height in pixels.
- cfg_rgb  in  24  fill colour {r,g,b}.
- commit  in  1  request: copy shadow to active at next frame start.
- commit_pending  out  1  commit requested, not yet applied.
- pix_valid  in  1  input pixel valid.
- x, y  in  11, 12  pixel coordinate.
- r, g, b  in  8 each  pixel colour.
- pix_valid_out  out  1  output valid.
- x_out, y_out, r_out, g_out, b_out  out  11/12/8/8/8  delayed coordinate and resolved colour.

## Operation
- Shadow write: occurs on a clk edge where cfg_valid && cfg_ready. The whole descriptor for cfg_slot is overwritten.
- cfg_ready = !commit_pending. Writes stall from the commit request until it is applied.
- commit sampled high while commit_pending=0 sets commit_pending on the next edge. commit while already pending has no effect.
- A cfg write and commit in the same cycle: the write lands in shadow and is part of that commit.
- Frame start: pix_valid && x==0 && y==0.
- Commit apply: at the first frame-start pixel seen on a cycle *after* commit_pending is set, active <= shadow (all slots) and commit_pending clears. A frame-start pixel coincident with the commit request does not trigger the apply.
- The frame-start pixel that triggers the apply is itself evaluated against the new table. Stage 1 muxes in shadow values on that cycle.
- Hit test per slot i: en && x >= X && x < X+W && y >= Y && y < Y+H.
  - Sums are evaluated at 12/13 bits, so edges near the coordinate maximum never wrap.
  - W=0 or H=0 never hits.
- Priority: highest slot index that hits wins and supplies its rgb. With no hit, input r/g/b pass through unchanged.
- x/y pass through unmodified. No backpressure: the pipeline advances every cycle regardless of pix_valid.
- Reset:
  - All shadow and active slots are cleared (en=0, so passthrough).
  - commit_pending=0, cfg_ready=1.
  - Both pipeline valid bits and all data outputs are 0.
  - A reset mid-frame drops in-flight pixels and any pending commit.

## Timing
- Latency is exactly 2 cycles from pix_valid/x/y/r/g/b to pix_valid_out and the data outputs.
- Stage 1 registers per-slot hit bits, the slot colours, and the pixel.
- Stage 2 registers the priority-selected colour.
- Throughput is 1 pixel/clk.
- pix_valid_out is pix_valid delayed by 2. Data outputs are defined only when pix_valid_out=1.
- commit_pending rises 1 cycle after commit. It falls on the edge that captures the triggering frame-start pixel.
- cfg_ready is combinational from commit_pending, so it goes low 1 cycle after commit.
- Shadow writes never affect output pixels until applied.
- Config writes are legal during active video.

## Test plan
- Reset passthrough:
  - Stimulus: rst 2 cycles, then stream (5,7,0x11,0x22,0x33) with pix_valid=1.
  - Required: out (5,7,0x11,0x22,0x33) exactly 2 cycles later. All outputs 0 during reset.
- Single rect edges:
  - Stimulus: slot0 = {en, x=10, y=20, w=4, h=2, rgb=FF0000}, commit, then a frame start.
  - Required:
    - x=10..13 with y=20..21 gives FF0000.
    - x=9, x=14, y=19, y=22 pass input through.
- Priority overlap:
  - Stimulus: slot1 = {0,0,8,8,00FF00} and slot3 = {4,4,8,8,0000FF}, committed.
  - Required: (5,5) gives 0000FF, (1,1) gives 00FF00, (10,10) gives 0000FF.
- Tear-free commit:
  - Stimulus: mid-frame, write slot0 colour 00FF00 and commit; continue current frame, then send (0,0).
  - Required:
    - Remainder of the current frame uses the old colour.
    - Pixel (0,0) and everything after it use 00FF00.
    - commit_pending falls at that edge.
- Stall and edge cases:
  - Stimulus: with commit_pending=1, hold cfg_valid.
    - Required: cfg_ready=0, no shadow change.
  - Stimulus: write cfg_slot=7 with NUM_RECTS=4.
    - Required: accepted, no effect.
  - Stimulus: x=2040, w=16.
    - Required: hits x=2040..2047 with no wrap false-hit at x=0..7.
  - Stimulus: w=0.
    - Required: no hit.
- Reset mid-operation:
  - Stimulus: assert rst with commit_pending=1 and 2 pixels in flight.
  - Required:
    - Next cycle: pix_valid_out=0, commit_pending=0, cfg_ready=1.
    - Subsequent pixels pass through unchanged.
